conv_window_feeder: RTL and testbench

//  Producer side of the convolution datapath. Accepts one raster-order pixel stream over valid/ready.

---
 rtl/conv_window_feeder.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: turns a raster-order pixel stream into KxK windows at a
// fixed stride, presented flattened on a valid/ready port for the MAC array.
// The last K rows live in a ring of row registers indexed by (row mod K).
// Optional build macro: CONV_FEEDER_COORD_EN adds win_row/win_col outputs.

module conv_window_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 7,
  parameter int IMG_H  = 7,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  localparam int OUT_W  = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H  = (IMG_H - K) / STRIDE + 1,
  localparam int WROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int WCOL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_W-1:0]       pix_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic                    win_last,
  output logic                    frame_done
`ifdef CONV_FEEDER_COORD_EN
  ,
  output logic [WROW_W-1:0]       win_row,
  output logic [WCOL_W-1:0]       win_col
`endif
);

  localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SLOT_W   = (K > 1) ? $clog2(K) : 1;
  localparam int W_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int BAND_W   = $clog2(OUT_H + 1);
  localparam int STEP_MOD = STRIDE % K;
  localparam int WIN_BITS = K * K * DATA_W;

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]  TRIG_FIRST = ROW_W'(K - 1);
  localparam logic [ROW_W-1:0]  ROW_STEP   = ROW_W'(STRIDE);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(K - 1);
  localparam logic [W_W-1:0]    W_LAST     = W_W'(OUT_W - 1);
  localparam logic [BAND_W-1:0] BAND_LAST  = BAND_W'(OUT_H - 1);
  localparam logic [BAND_W-1:0] BAND_ALL   = BAND_W'(OUT_H);

  typedef enum logic [1:0] {FILL, EMIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]   base_slot_q, base_slot_d;
  logic [ROW_W-1:0]    trig_row_q, trig_row_d;
  logic [BAND_W-1:0]   band_q, band_d;
  logic [W_W-1:0]      w_q, w_d;
  logic                last_row_seen_q, last_row_seen_d;
  logic                pix_ready_q, pix_ready_d;
  logic                win_valid_q, win_valid_d;
  logic [WIN_BITS-1:0] win_data_q, win_data_d;
  logic                win_last_q, win_last_d;
  logic                frame_done_q, frame_done_d;
`ifdef CONV_FEEDER_COORD_EN
  logic [WROW_W-1:0]   win_row_q, win_row_d;
  logic [WCOL_W-1:0]   win_col_q, win_col_d;
`endif

  logic [DATA_W-1:0]   ring_q [K][IMG_W];
  logic [WIN_BITS-1:0] win_next;
  logic [COL_W-1:0]    sel_col;
  logic [W_W-1:0]      w_next;
  logic                pix_fire, win_fire, row_end, frame_end;
  logic                band_trigger, band_final, w_final;

  assign pix_fire     = pix_valid && pix_ready_q;
  assign win_fire     = win_valid_q && win_ready;
  assign row_end      = pix_fire && (col_q == COL_LAST);
  assign frame_end    = row_end && (row_q == ROW_LAST);
  assign band_trigger = row_end && (band_q != BAND_ALL) && (row_q == trig_row_q);
  assign band_final   = (band_q == BAND_LAST);
  assign w_final      = (w_q == W_LAST);
  assign w_next       = w_final ? '0 : w_q + 1'b1;
  assign sel_col      = (state_q == EMIT) ? COL_W'(int'(w_next) * STRIDE) : '0;

  // Ring of row buffers: each accepted pixel lands in slot (row mod K) at its column
  always_ff @(posedge clock) begin
    if (pix_fire) begin
      ring_q[wr_slot_q][col_q] <= pix_data;
    end
  end

  // Gather the window at sel_col for the current band, forwarding the pixel written this cycle
  always_comb begin
    logic [SLOT_W-1:0] rd_slot;
    logic [COL_W-1:0]  rd_col;
    win_next = '0;
    rd_slot  = '0;
    rd_col   = '0;
    for (int i = 0; i < K; i++) begin
      rd_slot = SLOT_W'((int'(base_slot_q) + i) % K);
      for (int j = 0; j < K; j++) begin
        rd_col = COL_W'(int'(sel_col) + j);
        if (pix_fire && (rd_slot == wr_slot_q) && (rd_col == col_q)) begin
          win_next[(i*K+j)*DATA_W +: DATA_W] = pix_data;
        end else begin
          win_next[(i*K+j)*DATA_W +: DATA_W] = ring_q[rd_slot][rd_col];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fill rows, emit a band of windows, then close the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (band_trigger) begin
          state_d = EMIT;
        end else if (frame_end) begin
          state_d = DONE;
        end
      end
      EMIT: begin
        if (win_fire && w_final) begin
          state_d = (band_final && last_row_seen_q) ? DONE : FILL;
        end
      end
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output and counter logic: raster counters in FILL, window stepping in EMIT, clear in DONE
  always_comb begin
    int base_adv;
    col_d           = col_q;
    row_d           = row_q;
    wr_slot_d       = wr_slot_q;
    base_slot_d     = base_slot_q;
    trig_row_d      = trig_row_q;
    band_d          = band_q;
    w_d             = w_q;
    last_row_seen_d = last_row_seen_q;
    win_data_d      = win_data_q;
    win_last_d      = win_last_q;
`ifdef CONV_FEEDER_COORD_EN
    win_row_d       = win_row_q;
    win_col_d       = win_col_q;
`endif
    base_adv = int'(base_slot_q) + STEP_MOD;
    if (base_adv >= K) begin
      base_adv = base_adv - K;
    end
    case (state_q)
      FILL: begin
        if (pix_fire) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d           = '0;
              wr_slot_d       = '0;
              last_row_seen_d = 1'b1;
            end else begin
              row_d     = row_q + 1'b1;
              wr_slot_d = (wr_slot_q == SLOT_LAST) ? '0 : wr_slot_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (band_trigger) begin
          w_d        = '0;
          win_data_d = win_next;
          win_last_d = band_final && (W_LAST == '0);
`ifdef CONV_FEEDER_COORD_EN
          win_row_d  = WROW_W'(band_q);
          win_col_d  = '0;
`endif
        end
      end
      EMIT: begin
        if (win_fire) begin
          if (w_final) begin
            w_d         = '0;
            band_d      = band_q + 1'b1;
            base_slot_d = SLOT_W'(base_adv);
            if (!band_final) begin
              trig_row_d = trig_row_q + ROW_STEP;
            end
          end else begin
            w_d        = w_next;
            win_data_d = win_next;
            win_last_d = band_final && (w_next == W_LAST);
`ifdef CONV_FEEDER_COORD_EN
            win_col_d  = WCOL_W'(w_next);
`endif
          end
        end
      end
      DONE: begin
        col_d           = '0;
        row_d           = '0;
        wr_slot_d       = '0;
        base_slot_d     = '0;
        trig_row_d      = TRIG_FIRST;
        band_d          = '0;
        w_d             = '0;
        last_row_seen_d = 1'b0;
        win_last_d      = 1'b0;
`ifdef CONV_FEEDER_COORD_EN
        win_row_d       = '0;
        win_col_d       = '0;
`endif
      end
      default: ;
    endcase
    pix_ready_d  = (state_d == FILL);
    win_valid_d  = (state_d == EMIT);
    frame_done_d = (state_d == DONE);
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q           <= '0;
      row_q           <= '0;
      wr_slot_q       <= '0;
      base_slot_q     <= '0;
      trig_row_q      <= TRIG_FIRST;
      band_q          <= '0;
      w_q             <= '0;
      last_row_seen_q <= 1'b0;
      pix_ready_q     <= 1'b0;
      win_valid_q     <= 1'b0;
      win_data_q      <= '0;
      win_last_q      <= 1'b0;
      frame_done_q    <= 1'b0;
`ifdef CONV_FEEDER_COORD_EN
      win_row_q       <= '0;
      win_col_q       <= '0;
`endif
    end else begin
      col_q           <= col_d;
      row_q           <= row_d;
      wr_slot_q       <= wr_slot_d;
      base_slot_q     <= base_slot_d;
      trig_row_q      <= trig_row_d;
      band_q          <= band_d;
      w_q             <= w_d;
      last_row_seen_q <= last_row_seen_d;
      pix_ready_q     <= pix_ready_d;
      win_valid_q     <= win_valid_d;
      win_data_q      <= win_data_d;
      win_last_q      <= win_last_d;
      frame_done_q    <= frame_done_d;
`ifdef CONV_FEEDER_COORD_EN
      win_row_q       <= win_row_d;
      win_col_q       <= win_col_d;
`endif
    end
  end

  assign pix_ready  = pix_ready_q;
  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;
`ifdef CONV_FEEDER_COORD_EN
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Testbench for conv_window_feeder: drives frames, captures windows and
// compares them against a reference built directly from the image array.
// Define CONV_FEEDER_COORD_EN to also check win_row/win_col.

module tb_conv_window_feeder;

  localparam int DATA_W   = 8;
  localparam int IMG_W    = 7;
  localparam int IMG_H    = 7;
  localparam int K        = 3;
  localparam int STRIDE   = 2;
  localparam int OUT_W    = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H    = (IMG_H - K) / STRIDE + 1;
  localparam int NWIN     = OUT_W * OUT_H;
  localparam int WIN_BITS = K * K * DATA_W;
  localparam int WROW_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int WCOL_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic                clock     = 1'b0;
  logic                reset     = 1'b1;
  logic                pix_valid = 1'b0;
  logic                pix_ready;
  logic [DATA_W-1:0]   pix_data  = '0;
  logic                win_valid;
  logic                win_ready = 1'b0;
  logic [WIN_BITS-1:0] win_data;
  logic                win_last;
  logic                frame_done;
`ifdef CONV_FEEDER_COORD_EN
  logic [WROW_W-1:0]   win_row;
  logic [WCOL_W-1:0]   win_col;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0]   stream[$];
  logic [WIN_BITS-1:0] exp_data[$];
  logic [WIN_BITS-1:0] cap_data[$];
  bit                  exp_last[$];
  bit                  cap_last[$];
  int                  exp_row[$];
  int                  exp_col[$];
  int                  cap_row[$];
  int                  cap_col[$];
  int                  done_cycles[$];
  int                  last_cycles[$];
  int                  stall_err;
  int                  ready_err;
  bit                  timed_out;

  always #5 clock = ~clock;

  conv_window_feeder #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .STRIDE (STRIDE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_last   (win_last),
    .frame_done (frame_done)
`ifdef CONV_FEEDER_COORD_EN
    ,
    .win_row    (win_row),
    .win_col    (win_col)
`endif
  );

  // Reference: build one image (0 = all ones, 1 = r*IMG_W+c, else random),
  // queue its pixels and every expected window straight from the array
  function automatic void add_frame(input int mode);
    logic [DATA_W-1:0]   img [IMG_H][IMG_W];
    logic [WIN_BITS-1:0] w;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        case (mode)
          0:       img[r][c] = 8'h01;
          1:       img[r][c] = DATA_W'(r * IMG_W + c);
          default: img[r][c] = DATA_W'($urandom);
        endcase
        stream.push_back(img[r][c]);
      end
    end
    for (int oy = 0; oy < OUT_H; oy++) begin
      for (int ox = 0; ox < OUT_W; ox++) begin
        w = '0;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            w[(i*K+j)*DATA_W +: DATA_W] = img[oy*STRIDE+i][ox*STRIDE+j];
          end
        end
        exp_data.push_back(w);
        exp_last.push_back((oy == OUT_H - 1) && (ox == OUT_W - 1));
        exp_row.push_back(oy);
        exp_col.push_back(ox);
      end
    end
  endfunction

  task automatic clear_all();
    stream.delete();
    exp_data.delete();
    cap_data.delete();
    exp_last.delete();
    cap_last.delete();
    exp_row.delete();
    exp_col.delete();
    cap_row.delete();
    cap_col.delete();
    done_cycles.delete();
    last_cycles.delete();
  endtask

  // Drive the queued stream and record every window handshake; valid_mode 0 =
  // always valid, 1 = random; ready_mode 0 = always, 1 = one in three, 2 = random.
  // Stops after 'frames' frame_done pulses, or right after window number stop_after.
  task automatic run_stream(input int valid_mode, input int ready_mode,
                            input int frames, input int stop_after);
    int                  idx;
    int                  cyc;
    bit                  hold;
    bit                  prev_stall;
    bit                  fire;
    bit                  took;
    logic [WIN_BITS-1:0] prev_data;
    logic                prev_last;
    idx = 0; cyc = 0; hold = 0; prev_stall = 0;
    prev_data = '0; prev_last = 1'b0;
    timed_out = 0; stall_err = 0; ready_err = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (frame_done === 1'b1) done_cycles.push_back(cyc);
      if (frames > 0 && done_cycles.size() >= frames) break;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
      if (prev_stall && (win_data !== prev_data || win_last !== prev_last || win_valid !== 1'b1))
        stall_err++;
      if (win_valid === 1'b1 && pix_ready === 1'b1) ready_err++;
      case (ready_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = (cyc % 3 == 0);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      took = (win_valid === 1'b1) && win_ready;
      if (took) begin
        cap_data.push_back(win_data);
        cap_last.push_back(win_last === 1'b1);
`ifdef CONV_FEEDER_COORD_EN
        cap_row.push_back(int'(win_row));
        cap_col.push_back(int'(win_col));
`endif
        if (win_last === 1'b1) last_cycles.push_back(cyc);
        prev_stall = 0;
      end else begin
        prev_stall = (win_valid === 1'b1);
      end
      prev_data = win_data;
      prev_last = win_last;
      if (idx < stream.size()) begin
        if (!hold) pix_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        pix_data = stream[idx];
      end else begin
        pix_valid = 1'b0;
      end
      fire = pix_valid && (pix_ready === 1'b1);
      if (fire) idx++;
      hold = pix_valid && !fire;
      if (stop_after > 0 && took && cap_data.size() == stop_after) begin
        @(posedge clock);
        return;
      end
    end
    pix_valid = 1'b0;
    win_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_ready: got %b expected 0", pix_ready); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_win_valid: got %b expected 0", win_valid); end
    checks++; if (win_data !== '0) begin errors++; $display("[TB] FAIL reset_win_data: got %h expected 0", win_data); end
    checks++; if (win_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_win_last: got %b expected 0", win_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_rise: got %b expected 1", pix_ready); end
  endtask

  task automatic test_ones();
    int got_done, exp_done;
    clear_all();
    add_frame(0);
    run_stream(0, 0, 1, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL ones_timeout: got timeout expected frame_done"); end
    checks++; if (cap_data.size() !== NWIN) begin errors++; $display("[TB] FAIL ones_count: got %0d expected %0d", cap_data.size(), NWIN); end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++; if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++; $display("[TB] FAIL ones_win%0d: got %h last %0d expected %h last %0d", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    checks++; if (done_cycles.size() !== 1) begin errors++; $display("[TB] FAIL ones_done_count: got %0d expected 1", done_cycles.size()); end
    got_done = (done_cycles.size() > 0) ? done_cycles[0] : -2;
    exp_done = (last_cycles.size() > 0) ? last_cycles[0] + 1 : -1;
    checks++; if (got_done !== exp_done) begin errors++; $display("[TB] FAIL ones_done_timing: got cycle %0d expected %0d", got_done, exp_done); end
  endtask

  task automatic test_ramp();
    logic [DATA_W-1:0]   lits [3][9];
    int                  pos [3];
    logic [WIN_BITS-1:0] w, got;
    lits = '{'{0, 1, 2, 7, 8, 9, 14, 15, 16},
             '{16, 17, 18, 23, 24, 25, 30, 31, 32},
             '{32, 33, 34, 39, 40, 41, 46, 47, 48}};
    pos = '{0, 4, 8};
    clear_all();
    add_frame(1);
    run_stream(0, 0, 1, 0);
    checks++; if (cap_data.size() !== NWIN) begin errors++; $display("[TB] FAIL ramp_count: got %0d expected %0d", cap_data.size(), NWIN); end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++; if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++; $display("[TB] FAIL ramp_win%0d: got %h last %0d expected %h last %0d", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    for (int n = 0; n < 3; n++) begin
      w = '0;
      for (int e = 0; e < 9; e++) w[e*DATA_W +: DATA_W] = lits[n][e];
      got = (cap_data.size() > pos[n]) ? cap_data[pos[n]] : 'x;
      checks++; if (got !== w) begin errors++; $display("[TB] FAIL ramp_literal%0d: got %h expected %h", pos[n], got, w); end
    end
  endtask

  task automatic test_stall();
    clear_all();
    add_frame(1);
    run_stream(0, 1, 1, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL stall_timeout: got timeout expected frame_done"); end
    checks++; if (cap_data.size() !== NWIN) begin errors++; $display("[TB] FAIL stall_count: got %0d expected %0d", cap_data.size(), NWIN); end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++; if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++; $display("[TB] FAIL stall_win%0d: got %h last %0d expected %h last %0d", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    checks++; if (stall_err !== 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d changes expected 0", stall_err); end
    checks++; if (ready_err !== 0) begin errors++; $display("[TB] FAIL stall_pix_ready: got %0d cycles with pix_ready in EMIT expected 0", ready_err); end
  endtask

  task automatic test_random_valid();
    clear_all();
    add_frame(2);
    run_stream(1, 0, 1, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL rvalid_timeout: got timeout expected frame_done"); end
    checks++; if (cap_data.size() !== NWIN) begin errors++; $display("[TB] FAIL rvalid_count: got %0d expected %0d", cap_data.size(), NWIN); end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++; if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++; $display("[TB] FAIL rvalid_win%0d: got %h last %0d expected %h last %0d", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    checks++; if (ready_err !== 0) begin errors++; $display("[TB] FAIL rvalid_pix_ready: got %0d expected 0", ready_err); end
  endtask

  task automatic test_reset_mid();
    clear_all();
    add_frame(2);
    run_stream(0, 0, 0, 4);
    checks++; if (cap_data.size() !== 4) begin errors++; $display("[TB] FAIL mid_prefix_count: got %0d expected 4", cap_data.size()); end
    for (int k = 0; k < cap_data.size() && k < 4; k++) begin
      checks++; if (cap_data[k] !== exp_data[k]) begin errors++; $display("[TB] FAIL mid_prefix%0d: got %h expected %h", k, cap_data[k], exp_data[k]); end
    end
    #2;
    reset = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    #1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_win_valid: got %b expected 0", win_valid); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_pix_ready: got %b expected 0", pix_ready); end
    @(negedge clock) reset = 1'b1;
    clear_all();
    add_frame(1);
    run_stream(0, 0, 1, 0);
    checks++; if (cap_data.size() !== NWIN) begin errors++; $display("[TB] FAIL mid_after_count: got %0d expected %0d", cap_data.size(), NWIN); end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++; if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++; $display("[TB] FAIL mid_after_win%0d: got %h last %0d expected %h last %0d", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    add_frame(2);
    add_frame(2);
    run_stream(0, 2, 2, 0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL b2b_timeout: got timeout expected two frame_done"); end
    checks++; if (cap_data.size() !== 2 * NWIN) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", cap_data.size(), 2 * NWIN); end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++; if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++; $display("[TB] FAIL b2b_win%0d: got %h last %0d expected %h last %0d", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
`ifdef CONV_FEEDER_COORD_EN
      checks++; if (cap_row[k] !== exp_row[k] || cap_col[k] !== exp_col[k]) begin
        errors++; $display("[TB] FAIL b2b_coord%0d: got (%0d,%0d) expected (%0d,%0d)", k, cap_row[k], cap_col[k], exp_row[k], exp_col[k]);
      end
`endif
    end
    checks++; if (done_cycles.size() !== 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cycles.size()); end
    checks++; if (stall_err !== 0) begin errors++; $display("[TB] FAIL b2b_hold: got %0d changes expected 0", stall_err); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp();
    test_stall();
    test_random_valid();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
